// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-SRAM arbiter for fetch and data ports, data wins; optional fetch buffer under MEM_ARB_IBUF_EN
module mem_arbiter #(
    parameter int SRAM_WAIT = 1,
    parameter int ADDR_W    = 20
) (
    input  logic              clk_50M,
    input  logic              reset_btn,
    input  logic              if_req,
    input  logic [31:0]       if_pc,
    output logic [31:0]       if_instr,
    output logic              if_valid,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [4:0]        mem_ctrl_signal,
    output logic [31:0]       mem_rdata,
    output logic              mem_stall,
    output logic              mem_err,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic [3:0]        sram_be_n,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_data_oe
);

    typedef enum logic [2:0] {S_IDLE, S_D_ACC, S_D_DONE, S_I_ACC, S_I_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_wait;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [31:0]       r_sram_wdata;
    logic [3:0]        r_sram_be_n;
    logic              r_sram_ce_n;
    logic              r_sram_oe_n;
    logic              r_sram_we_n;
    logic              r_sram_data_oe;
    logic [31:0]       r_if_instr;
    logic [31:0]       r_mem_rdata;
    logic [1:0]        r_lo;
    logic [1:0]        r_size;
    logic              r_sign;
    logic              r_write;

    logic [1:0]        w_size;
    logic              w_misal;
    logic              w_d_go;
    logic              w_last;
    logic              w_hit;
    logic [3:0]        w_be_n;
    logic [31:0]       w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;
    logic              w_unused;

    assign w_size   = mem_ctrl_signal[3:2];
    assign w_misal  = mem_ctrl_signal[0] &&
                      ((w_size == 2'b01 && mem_addr[0]) ||
                       (w_size == 2'b10 && mem_addr[1:0] != 2'b00) ||
                       (w_size == 2'b11));
    assign w_d_go   = mem_ctrl_signal[0] && !w_misal;
    assign w_last   = (r_wait == 3'd0);
    assign w_unused = ^{mem_addr[31:ADDR_W+2], if_pc[31:ADDR_W+2], if_pc[1:0]};

`ifdef MEM_ARB_IBUF_EN
    logic [ADDR_W-1:0] r_tag;
    logic              r_tag_v;
    assign w_hit = r_tag_v && (r_tag == if_pc[ADDR_W+1:2]);
`else
    assign w_hit = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_d_go)
                    w_next = S_D_ACC;
                else if (if_req)
                    w_next = w_hit ? S_I_DONE : S_I_ACC;
            end
            S_D_ACC:  if (w_last) w_next = S_D_DONE;
            S_I_ACC:  if (w_last) w_next = S_I_DONE;
            S_D_DONE: w_next = S_IDLE;
            S_I_DONE: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Store lane steering: replicate the datum, enable only the addressed lanes.
    always_comb begin
        w_be_n  = 4'h0;
        w_wdata = mem_wdata;
        case (w_size)
            2'b00: begin
                w_be_n  = ~(4'b0001 << mem_addr[1:0]);
                w_wdata = {4{mem_wdata[7:0]}};
            end
            2'b01: begin
                w_be_n  = mem_addr[1] ? 4'b0011 : 4'b1100;
                w_wdata = {2{mem_wdata[15:0]}};
            end
            default: begin
                w_be_n  = 4'h0;
                w_wdata = mem_wdata;
            end
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_lo)
            2'd0: w_byte = sram_rdata[7:0];
            2'd1: w_byte = sram_rdata[15:8];
            2'd2: w_byte = sram_rdata[23:16];
            2'd3: w_byte = sram_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = r_lo[1] ? sram_rdata[31:16] : sram_rdata[15:0];
        case (r_size)
            2'b00:   w_load = {{24{r_sign & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_sign & w_half[15]}}, w_half};
            default: w_load = sram_rdata;
        endcase
    end

    always_ff @(posedge clk_50M or negedge reset_btn) begin
        if (!reset_btn) begin
            r_state        <= S_IDLE;
            r_wait         <= 3'd0;
            r_sram_addr    <= '0;
            r_sram_wdata   <= 32'h0;
            r_sram_be_n    <= 4'hF;
            r_sram_ce_n    <= 1'b1;
            r_sram_oe_n    <= 1'b1;
            r_sram_we_n    <= 1'b1;
            r_sram_data_oe <= 1'b0;
            r_if_instr     <= 32'h0;
            r_mem_rdata    <= 32'h0;
            r_lo           <= 2'd0;
            r_size         <= 2'd0;
            r_sign         <= 1'b0;
            r_write        <= 1'b0;
`ifdef MEM_ARB_IBUF_EN
            r_tag          <= '0;
            r_tag_v        <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_misal)
                        r_mem_rdata <= 32'h0;
                    if (w_d_go) begin
                        r_sram_ce_n <= 1'b0;
                        r_sram_addr <= mem_addr[ADDR_W+1:2];
                        r_wait      <= 3'(SRAM_WAIT);
                        r_lo        <= mem_addr[1:0];
                        r_size      <= w_size;
                        r_sign      <= mem_ctrl_signal[4];
                        r_write     <= mem_ctrl_signal[1];
                        if (mem_ctrl_signal[1]) begin
                            r_sram_we_n    <= 1'b0;
                            r_sram_data_oe <= 1'b1;
                            r_sram_be_n    <= w_be_n;
                            r_sram_wdata   <= w_wdata;
`ifdef MEM_ARB_IBUF_EN
                            if (r_tag == mem_addr[ADDR_W+1:2])
                                r_tag_v <= 1'b0;
`endif
                        end else begin
                            r_sram_oe_n    <= 1'b0;
                            r_sram_be_n    <= 4'h0;
                            r_sram_data_oe <= 1'b0;
                        end
                    end else if (if_req && !w_hit) begin
                        r_sram_ce_n    <= 1'b0;
                        r_sram_oe_n    <= 1'b0;
                        r_sram_be_n    <= 4'h0;
                        r_sram_data_oe <= 1'b0;
                        r_sram_addr    <= if_pc[ADDR_W+1:2];
                        r_wait         <= 3'(SRAM_WAIT);
                    end
                end
                S_D_ACC, S_I_ACC: begin
                    if (w_last) begin
                        r_sram_ce_n <= 1'b1;
                        r_sram_oe_n <= 1'b1;
                        r_sram_we_n <= 1'b1;
                        if (r_state == S_D_ACC) begin
                            if (!r_write)
                                r_mem_rdata <= w_load;
                        end else begin
                            r_if_instr <= sram_rdata;
`ifdef MEM_ARB_IBUF_EN
                            r_tag   <= r_sram_addr;
                            r_tag_v <= 1'b1;
`endif
                        end
                    end else begin
                        r_wait <= r_wait - 3'd1;
                    end
                end
                // Address/data were held through DONE; release the bus now.
                S_D_DONE, S_I_DONE: begin
                    r_sram_be_n    <= 4'hF;
                    r_sram_data_oe <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mem_err      = reset_btn && (r_state == S_IDLE) && w_misal;
    assign mem_rdata    = mem_err ? 32'h0 : r_mem_rdata;
    assign if_instr     = r_if_instr;
    assign if_valid     = (r_state == S_I_DONE);
    assign mem_stall    = reset_btn &&
                          ((w_d_go && r_state != S_D_DONE) ||
                           (if_req && r_state != S_I_DONE));
    assign sram_addr    = r_sram_addr;
    assign sram_wdata   = r_sram_wdata;
    assign sram_be_n    = r_sram_be_n;
    assign sram_ce_n    = r_sram_ce_n;
    assign sram_oe_n    = r_sram_oe_n;
    assign sram_we_n    = r_sram_we_n;
    assign sram_data_oe = r_sram_data_oe;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk_50M = 1'b0;
    logic        reset_btn;
    logic        if_req;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [4:0]  mem_ctrl_signal;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        mem_err;
    logic [19:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [3:0]  sram_be_n;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_data_oe;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.SRAM_WAIT(1), .ADDR_W(20)) dut (
        .clk_50M(clk_50M), .reset_btn(reset_btn),
        .if_req(if_req), .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ctrl_signal(mem_ctrl_signal),
        .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_err(mem_err),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_be_n(sram_be_n), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_data_oe(sram_data_oe)
    );

    always #10 clk_50M = ~clk_50M;

    always_comb begin
        case (sram_addr)
            20'd0:   sram_rdata = 32'h80FF_0000;
            20'd1:   sram_rdata = 32'h1234_5678;
            20'd2:   sram_rdata = 32'h3401_0002;
            20'd4:   sram_rdata = 32'hDEAD_BEEF;
            default: sram_rdata = 32'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_50M);
            #1;
        end
    endtask

    initial begin
        reset_btn = 1'b0; if_req = 1'b1; if_pc = 32'h0;
        mem_addr = 32'h0; mem_wdata = 32'h0; mem_ctrl_signal = 5'b0;
        #25;
        chk("rst_ce_n", sram_ce_n, 1);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_be_n", sram_be_n, 4'hF);
        chk("rst_data_oe", sram_data_oe, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_wdata", sram_wdata, 0);
        chk("rst_instr", if_instr, 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_err", mem_err, 0);
        chk("rst_stall", mem_stall, 0);
        if_req = 1'b0;
        @(negedge clk_50M);
        reset_btn = 1'b1;
        step(1);

        // fetch only
        if_req = 1'b1; if_pc = 32'h8;
        #1 chk("f_stall_idle", mem_stall, 1);
        step(1);
        chk("f_addr", sram_addr, 2);
        chk("f_ce_n", sram_ce_n, 0);
        chk("f_oe_n", sram_oe_n, 0);
        step(1);
        chk("f_valid_early", if_valid, 0);
        step(1);
        chk("f_valid", if_valid, 1);
        chk("f_instr", if_instr, 32'h3401_0002);
        chk("f_stall_done", mem_stall, 0);
        chk("f_ce_n_done", sram_ce_n, 1);
        if_req = 1'b0;
        step(1);
        chk("f_valid_off", if_valid, 0);
        chk("f_instr_hold", if_instr, 32'h3401_0002);

        // simultaneous data load and fetch
        mem_ctrl_signal = 5'b01001; mem_addr = 32'h10; if_req = 1'b1; if_pc = 32'h4;
        step(1);
        chk("s_addr_d", sram_addr, 4);
        chk("s_stall1", mem_stall, 1);
        step(2);
        chk("s_rdata", mem_rdata, 32'hDEAD_BEEF);
        chk("s_valid_d", if_valid, 0);
        chk("s_stall_ddone", mem_stall, 1);
        mem_ctrl_signal = 5'b0;
        step(1);
        chk("s_stall_idle", mem_stall, 1);
        step(1);
        chk("s_addr_i", sram_addr, 1);
        step(2);
        chk("s_valid_i", if_valid, 1);
        chk("s_instr", if_instr, 32'h1234_5678);
        chk("s_stall_idone", mem_stall, 0);
        if_req = 1'b0;
        step(1);

        // store byte
        mem_ctrl_signal = 5'b00011; mem_addr = 32'h13; mem_wdata = 32'hAB;
        step(1);
        chk("sb_be_n", sram_be_n, 4'b0111);
        chk("sb_wdata", sram_wdata, 32'hABAB_ABAB);
        chk("sb_we_n1", sram_we_n, 0);
        chk("sb_oe_n", sram_oe_n, 1);
        chk("sb_data_oe", sram_data_oe, 1);
        chk("sb_addr", sram_addr, 4);
        step(1);
        chk("sb_we_n2", sram_we_n, 0);
        step(1);
        chk("sb_we_n_done", sram_we_n, 1);
        chk("sb_data_oe_hold", sram_data_oe, 1);
        chk("sb_stall_done", mem_stall, 0);
        mem_ctrl_signal = 5'b0;
        step(1);
        chk("sb_data_oe_off", sram_data_oe, 0);
        chk("sb_rdata_hold", mem_rdata, 32'hDEAD_BEEF);

        // signed byte load
        mem_ctrl_signal = 5'b10001; mem_addr = 32'h2;
        step(3);
        chk("lb_signed", mem_rdata, 32'hFFFF_FFFF);
        mem_ctrl_signal = 5'b0;
        step(1);

        // unsigned half load
        mem_ctrl_signal = 5'b00101; mem_addr = 32'h2;
        step(3);
        chk("lh_unsigned", mem_rdata, 32'h0000_80FF);
        mem_ctrl_signal = 5'b0;
        step(1);
        chk("lh_hold", mem_rdata, 32'h0000_80FF);

        // misaligned word
        mem_ctrl_signal = 5'b01001; mem_addr = 32'h2;
        #1;
        chk("mis_err", mem_err, 1);
        chk("mis_stall", mem_stall, 0);
        chk("mis_rdata", mem_rdata, 0);
        step(1);
        chk("mis_ce_n", sram_ce_n, 1);
        mem_ctrl_signal = 5'b0;
        #1 chk("mis_err_off", mem_err, 0);

        // reset during a data access
        mem_ctrl_signal = 5'b01001; mem_addr = 32'h10;
        step(1);
        chk("ra_ce_n_active", sram_ce_n, 0);
        reset_btn = 1'b0;
        #1;
        chk("ra_ce_n", sram_ce_n, 1);
        chk("ra_oe_n", sram_oe_n, 1);
        chk("ra_be_n", sram_be_n, 4'hF);
        chk("ra_stall", mem_stall, 0);
        chk("ra_rdata", mem_rdata, 0);
        chk("ra_instr", if_instr, 0);
        mem_ctrl_signal = 5'b0;
        #3 reset_btn = 1'b1;
        step(1);
        chk("ra_no_retry", sram_ce_n, 1);
        step(1);

`ifdef MEM_ARB_IBUF_EN
        if_req = 1'b1; if_pc = 32'h8;
        step(3);
        chk("ib_miss_valid", if_valid, 1);
        if_req = 1'b0;
        step(1);
        if_req = 1'b1;
        step(1);
        chk("ib_hit_valid", if_valid, 1);
        chk("ib_hit_ce_n", sram_ce_n, 1);
        chk("ib_hit_instr", if_instr, 32'h3401_0002);
        if_req = 1'b0;
        step(1);
        mem_ctrl_signal = 5'b01011; mem_addr = 32'h8; mem_wdata = 32'h0;
        step(3);
        mem_ctrl_signal = 5'b0;
        step(1);
        if_req = 1'b1;
        step(1);
        chk("ib_inv_ce_n", sram_ce_n, 0);
        chk("ib_inv_valid", if_valid, 0);
        step(2);
        chk("ib_inv_done", if_valid, 1);
        if_req = 1'b0;
        step(1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one external 32-bit SRAM between cpu_core instruction fetch (pc_out/instruction) and the data port (mem_addr/mem_wdata/mem_rdata/mem_ctrl_signal).
- Generates mem_stall so the pipeline freezes while either request is outstanding.
- Sits between cpu_core and the board SRAM pins. Data accesses win over fetch.

Parameters:
SRAM_WAIT, 1, extra wait cycles per SRAM access; legal range 0..7. The ACCESS state lasts SRAM_WAIT+1 cycles.
ADDR_W, 20, SRAM word-address width.

Ports:
clk_50M  in  1  system clock; all state changes on the rising edge
reset_btn  in  1  reset, asynchronous, active-low
if_req  in  1  fetch request
if_pc  in  32  fetch byte address; word aligned
if_instr  out  32  fetched instruction
if_valid  out  1  fetch complete; one-cycle pulse
mem_addr  in  32  data byte address
mem_wdata  in  32  store data, right-justified
mem_ctrl_signal  in  5  [0] enable, [1] write, [3:2] size (00 byte, 01 half, 10 word), [4] sign-extend load
mem_rdata  out  32  load result, aligned and extended
mem_stall  out  1  pipeline stall
mem_err  out  1  misaligned-access pulse
sram_addr  out  ADDR_W  word address = byte address [ADDR_W+1:2]
sram_wdata  out  32  write data, lane-shifted
sram_rdata  in  32  read data
sram_be_n  out  4  byte enables, active-low
sram_ce_n  out  1  SRAM chip enable, active-low
sram_oe_n  out  1  SRAM output enable, active-low
sram_we_n  out  1  SRAM write enable, active-low
sram_data_oe  out  1  top-level tristate enable; 1 during writes

Behaviour:
- Reset (asynchronous, while reset_btn=0):
  - State IDLE; wait counter cleared.
  - if_instr=0, mem_rdata=0, if_valid=0, mem_err=0, mem_stall=0.
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_be_n=4'hF, sram_data_oe=0, sram_addr=0, sram_wdata=0.
  - Assertion mid-access aborts the access immediately; no retry after release.
- States: IDLE, D_ACC, D_DONE, I_ACC, I_DONE.
- IDLE transitions:
  - ctrl[0]=1 and aligned -> D_ACC.
  - Otherwise if_req=1 -> I_ACC.
  - Misaligned data access (half with addr[0]=1, word with addr[1:0]!=0, or size 11) -> stay IDLE, mem_err=1 for one cycle, no SRAM cycle, mem_rdata=0. The request counts as served and mem_stall=0 that cycle.
- D_ACC / I_ACC:
  - Outputs registered on entry and held constant for SRAM_WAIT+1 cycles.
  - sram_ce_n=0 throughout.
  - Read: sram_oe_n=0, sram_be_n=0.
  - Write: sram_we_n=0, sram_data_oe=1.
  - On the last cycle, latch sram_rdata and go to the matching DONE state.
- D_DONE / I_DONE:
  - Exactly one cycle. sram_ce_n, sram_oe_n and sram_we_n return to 1.
  - sram_addr, sram_wdata and sram_data_oe held for hold time.
  - D_DONE drives mem_rdata; I_DONE drives if_instr and pulses if_valid.
  - Next state IDLE. A still-pending if_req is accepted from IDLE on the following cycle.
- Latency: request sampled in IDLE -> DONE after SRAM_WAIT+2 edges. Default: result visible 3 cycles after the request.
- mem_stall, combinational:
  - 1 when (ctrl[0]=1 and state!=D_DONE and the access is not misaligned) or (if_req=1 and state!=I_DONE).
  - Forced 0 during reset.
  - A data access followed by a fetch in the same instruction keeps mem_stall high until I_DONE.
- Store lanes:
  - Byte: be_n = ~(4'b0001<<addr[1:0]); wdata byte replicated to all lanes.
  - Half: be_n = addr[1] ? 4'b0011 : 4'b1100; wdata halfword replicated.
  - Word: be_n = 0.
- Load: select the lane by addr[1:0] and right-justify. Sign-extend if ctrl[4]=1, else zero-extend. Word loads pass through.
- mem_rdata and if_instr hold their last value until the next DONE of the same type.

Optional Feature:
MEM_ARB_IBUF_EN
- Defined: single-entry fetch buffer (tag = if_pc word address, valid bit, both cleared by reset).
  - In IDLE with no data access, a fetch whose if_pc matches a valid tag goes straight to I_DONE; no SRAM cycle.
  - Any data write whose word address equals the tag clears the valid bit.
- Undefined: every fetch performs an SRAM access.

Test Plan:
- Reset with SRAM_WAIT=1: hold reset_btn=0 -> all outputs at reset values, sram_ce_n=1, mem_stall=0.
- Fetch only: if_req=1, if_pc=0x0000_0008, sram_rdata=0x3401_0002 -> sram_addr=2; if_valid=1 and if_instr=0x3401_0002 on cycle 3; mem_stall=0 that cycle.
- Simultaneous requests: ctrl=5'b01001 (word load), addr=0x10 (sram_rdata=0xDEAD_BEEF); if_req=1, if_pc=0x4 (sram_rdata=0x1234_5678 during the fetch) -> D_DONE first with mem_rdata=0xDEAD_BEEF; then I_DONE with if_instr=0x1234_5678; mem_stall high until I_DONE.
- Store byte: ctrl=5'b00011, addr=0x13, wdata=0xAB -> sram_be_n=4'b0111, sram_wdata=0xABABABAB, sram_we_n=0 for 2 cycles, sram_data_oe=1.
- Loads at addr=0x2, sram_rdata=0x80FF_0000:
  - Signed byte, ctrl=5'b10001 -> mem_rdata=0xFFFF_FFFF.
  - Unsigned half, ctrl=5'b00101 -> mem_rdata=0x0000_80FF.
  - Misaligned word at 0x2 -> mem_err pulse, no ce_n low.
- Reset mid-access: drop reset_btn during D_ACC -> outputs return to reset values immediately, with no clock edge needed.
- IBUF (if enabled): fetch 0x8 twice -> second fetch completes in 1 cycle with no ce_n low. Then store a word to 0x8 and fetch again -> full SRAM access.
